// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one FP adder among NUM_REQ requesters, one op in flight.
// Grant in IDLE, ADD_LATENCY EXEC cycles, then result held in RESP until rsp_ready.
module fp_add_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int ADD_LATENCY = 1,
   parameter int ID_W        = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*32-1:0]  req_a,
   input  logic [NUM_REQ*32-1:0]  req_b,
   output logic [31:0]            add_a,
   output logic [31:0]            add_b,
   output logic                   add_start,
   input  logic [31:0]            add_result,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [31:0]            rsp_result,
   output logic                   busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [ID_W-1:0] last_grant_q, last_grant_d;
   logic [ID_W-1:0] op_id_q, op_id_d;
   logic [ID_W-1:0] rsp_id_q, rsp_id_d;
   logic [31:0]     op_a_q, op_a_d;
   logic [31:0]     op_b_q, op_b_d;
   logic [31:0]     rsp_result_q, rsp_result_d;

   logic [ID_W-1:0] cand;
   logic [ID_W-1:0] grant_idx;
   logic            grant_found;
   logic            transfer;

   // Search starts just after the last winner so every requester gets a turn.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      op_id_d      = op_id_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      req_ready    = '0;
      add_start    = 1'b0;
      transfer     = 1'b0;

      case (state_q)
         IDLE: begin
            if (grant_found && !reset) begin
               req_ready = NUM_REQ'(1) << grant_idx;
            end
            transfer = |(req_valid & req_ready);
            if (transfer) begin
               op_a_d       = req_a[32*int'(grant_idx) +: 32];
               op_b_d       = req_b[32*int'(grant_idx) +: 32];
               op_id_d      = grant_idx;
               last_grant_d = grant_idx;
               cnt_d        = 4'(ADD_LATENCY);
               state_d      = EXEC;
            end
         end
         EXEC: begin
            add_start = (cnt_q == 4'(ADD_LATENCY));
            cnt_d     = cnt_q - 4'd1;
            // Only the final EXEC cycle carries a valid adder result.
            if (cnt_q == 4'd1) begin
               rsp_result_d = add_result;
               rsp_id_d     = op_id_q;
               state_d      = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         last_grant_q <= ID_W'(NUM_REQ - 1);
         op_id_q      <= '0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         op_id_q      <= op_id_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
      end
   end

   assign add_a      = op_a_q;
   assign add_b      = op_b_q;
   assign rsp_valid  = (state_q == RESP);
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: two instances (latency 1 and 3) checked each cycle against
// a transaction-level model, plus directed vectors with hand-computed results.
module tb_fp_add_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [3:0]   rv1, rdy1, rv3, rdy3;
   logic [127:0] ra1, rb1, ra3, rb3;
   logic [31:0]  aa1, ab1, res1, rres1, aa3, ab3, res3, rres3;
   logic         st1, vld1, ack1, bsy1, st3, vld3, ack3, bsy3;
   logic [1:0]   id1, id3;

   fp_add_arbiter #(.NUM_REQ(4), .ADD_LATENCY(1)) u_l1 (
      .clk(clk), .reset(rst), .req_valid(rv1), .req_ready(rdy1), .req_a(ra1), .req_b(rb1),
      .add_a(aa1), .add_b(ab1), .add_start(st1), .add_result(res1), .rsp_valid(vld1),
      .rsp_ready(ack1), .rsp_id(id1), .rsp_result(rres1), .busy(bsy1));

   fp_add_arbiter #(.NUM_REQ(4), .ADD_LATENCY(3)) u_l3 (
      .clk(clk), .reset(rst), .req_valid(rv3), .req_ready(rdy3), .req_a(ra3), .req_b(rb3),
      .add_a(aa3), .add_b(ab3), .add_start(st3), .add_result(res3), .rsp_valid(vld3),
      .rsp_ready(ack3), .rsp_id(id3), .rsp_result(rres3), .busy(bsy3));

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [3:0] v, input int lg);
      for (int k = 1; k <= 4; k++) begin
         if (v[(lg + k) % 4]) return (lg + k) % 4;
      end
      return -1;
   endfunction

   // Model: age = cycles since grant (-1 when idle); EXEC is age 1..L, response is age L+1.
   int          age [2];
   int          lg [2];
   int          mid [2];
   int          mrid [2];
   logic [31:0] ma [2];
   logic [31:0] mb [2];
   logic [31:0] mres [2];

   task automatic model_one(input int d, input int L, input logic [3:0] v,
                            input logic [127:0] a, input logic [127:0] b,
                            input logic [31:0] res, input logic ack);
      int p;
      if (rst) begin
         age[d] = -1; lg[d] = 3; mid[d] = 0; mrid[d] = 0;
         ma[d] = '0; mb[d] = '0; mres[d] = '0;
      end else if (age[d] < 0) begin
         p = pick(v, lg[d]);
         if (p >= 0) begin
            lg[d] = p; mid[d] = p; ma[d] = a[32*p +: 32]; mb[d] = b[32*p +: 32]; age[d] = 1;
         end
      end else if (age[d] < L) begin
         age[d] = age[d] + 1;
      end else if (age[d] == L) begin
         mres[d] = res; mrid[d] = mid[d]; age[d] = L + 1;
      end else if (ack) begin
         age[d] = -1;
      end
   endtask

   always @(posedge clk or posedge rst) begin
      model_one(0, 1, rv1, ra1, rb1, res1, ack1);
      model_one(1, 3, rv3, ra3, rb3, res3, ack3);
   end

   task automatic cmp_one(input int d, input int L, input logic [3:0] v, input logic [3:0] rdy,
                          input logic st, input logic bsy, input logic vld, input logic [31:0] aa,
                          input logic [31:0] ab, input logic [1:0] id, input logic [31:0] rres);
      int e;
      logic [3:0] er;
      e  = (age[d] < 0 && !rst) ? pick(v, lg[d]) : -1;
      er = (e >= 0) ? (4'b0001 << e) : 4'b0000;
      chk($sformatf("m%0d_req_ready", d), 32'(rdy), 32'(er));
      chk($sformatf("m%0d_add_start", d), 32'(st), 32'(age[d] == 1));
      chk($sformatf("m%0d_busy", d), 32'(bsy), 32'(age[d] >= 0));
      chk($sformatf("m%0d_rsp_valid", d), 32'(vld), 32'(age[d] == L + 1));
      chk($sformatf("m%0d_add_a", d), aa, ma[d]);
      chk($sformatf("m%0d_add_b", d), ab, mb[d]);
      chk($sformatf("m%0d_rsp_id", d), 32'(id), 32'(mrid[d]));
      chk($sformatf("m%0d_rsp_result", d), rres, mres[d]);
   endtask

   always @(negedge clk) begin
      cmp_one(0, 1, rv1, rdy1, st1, bsy1, vld1, aa1, ab1, id1, rres1);
      cmp_one(1, 3, rv3, rdy3, st3, bsy3, vld3, aa3, ab3, id3, rres3);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   int gc[$];
   logic [3:0] gv[$];
   int ns;

   initial begin
      rv1 = '0; ra1 = '0; rb1 = '0; res1 = '0; ack1 = 1'b1;
      rv3 = '0; ra3 = '0; rb3 = '0; res3 = '0; ack3 = 1'b1;
      tick(); tick();
      @(negedge clk);
      chk("rst_busy", 32'(bsy1), 0);
      chk("rst_add_a", aa1, 0);
      chk("rst_rsp_valid", 32'(vld1), 0);
      chk("rst_rsp_result", rres1, 0);
      tick(); rst = 1'b0;

      // single op, L=1
      rv1 = 4'b0001; ra1[31:0] = 32'h3F80_0000; rb1[31:0] = 32'h4000_0000; res1 = 32'h4040_0000;
      @(negedge clk);
      chk("t1_ready_c0", 32'(rdy1), 32'h1);
      chk("t1_start_c0", 32'(st1), 0);
      tick(); rv1 = '0;
      @(negedge clk);
      chk("t1_start_c1", 32'(st1), 1);
      chk("t1_add_a", aa1, 32'h3F80_0000);
      chk("t1_add_b", ab1, 32'h4000_0000);
      chk("t1_valid_c1", 32'(vld1), 0);
      tick();
      @(negedge clk);
      chk("t1_valid_c2", 32'(vld1), 1);
      chk("t1_result", rres1, 32'h4040_0000);
      chk("t1_id", 32'(id1), 0);
      tick();
      @(negedge clk);
      chk("t1_valid_c3", 32'(vld1), 0);
      chk("t1_busy_c3", 32'(bsy1), 0);

      // all four requesting from reset pointer
      tick(); rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 1; i < 4; i++) begin
         ra1[32*i +: 32] = 32'h1000_0000 * i;
         rb1[32*i +: 32] = 32'h0000_0100 * i;
      end
      rv1 = 4'b1111;
      for (int c = 0; c < 13; c++) begin
         @(negedge clk);
         if (rdy1 != 4'b0000) begin
            gc.push_back(c);
            gv.push_back(rdy1);
         end
         tick();
      end
      rv1 = '0;
      chk("t2_grant_count", 32'(gc.size()), 5);
      for (int k = 0; k < gc.size() && k < 5; k++) begin
         chk("t2_grant_cycle", 32'(gc[k]), 32'(3 * k));
         chk("t2_grant_onehot", 32'(gv[k]), 32'(4'b0001 << (k % 4)));
      end
      tick(); tick();

      // stalled response; inf + -inf returns the adder's NaN untouched
      ack1 = 1'b0; rv1 = 4'b0010;
      ra1[63:32] = 32'h7F80_0000; rb1[63:32] = 32'hFF80_0000; res1 = 32'h7FFF_FFFF;
      @(negedge clk);
      chk("t3_ready_c0", 32'(rdy1), 32'h2);
      tick(); rv1 = 4'b1111;
      @(negedge clk);
      chk("t3_start", 32'(st1), 1);
      chk("t3_ready_exec", 32'(rdy1), 0);
      tick(); res1 = 32'h1234_5678;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_hold_valid", 32'(vld1), 1);
         chk("t3_hold_id", 32'(id1), 1);
         chk("t3_hold_result", rres1, 32'h7FFF_FFFF);
         chk("t3_hold_ready", 32'(rdy1), 0);
         tick(); res1 = res1 + 32'd1;
      end
      ack1 = 1'b1;
      @(negedge clk);
      chk("t3_accept_valid", 32'(vld1), 1);
      tick();
      @(negedge clk);
      chk("t3_after_valid", 32'(vld1), 0);
      chk("t3_after_ready", 32'(rdy1), 32'h4);
      tick(); rv1 = '0;
      tick(); tick();

      // L=3 capture point
      rv3 = 4'b0001; ra3[31:0] = 32'h3F80_0000; rb3[31:0] = 32'h3F80_0000; res3 = 32'hA000_0000;
      ns = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (st3) ns++;
         if (k == 4) begin
            chk("t4_valid", 32'(vld3), 1);
            chk("t4_result", rres3, 32'hA000_0003);
         end
         tick();
         if (k == 0) rv3 = '0;
         res3 = 32'hA000_0000 + 32'(k + 1);
      end
      chk("t4_start_pulses", 32'(ns), 1);

      // async reset in the middle of EXEC
      rv1 = 4'b0001; res1 = '0;
      @(negedge clk);
      chk("t5_ready_pre", 32'(rdy1), 32'h1);
      tick(); rv1 = 4'b0101;
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("t5_rst_ready", 32'(rdy1), 0);
      chk("t5_rst_add_a", aa1, 0);
      chk("t5_rst_add_b", ab1, 0);
      chk("t5_rst_start", 32'(st1), 0);
      chk("t5_rst_valid", 32'(vld1), 0);
      chk("t5_rst_busy", 32'(bsy1), 0);
      chk("t5_rst_id", 32'(id1), 0);
      chk("t5_rst_result", rres1, 0);
      tick(); tick(); rst = 1'b0;
      @(negedge clk);
      chk("t5_first_grant", 32'(rdy1), 32'h1);
      tick(); rv1 = '0;
      tick(); tick();
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
